// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense controller.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    VEND   = 3'd2,
    CHANGE = 3'd3,
    DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_NO_STOCK = 2'd1,
    ST_NO_FUNDS = 2'd2,
    ST_TIMEOUT  = 2'd3
  } status_t;

  localparam int NUM_DENOMS = 5;

  // Coin values indexed by coin_denom, largest first so index order is greedy order.
  localparam int DENOM_VALUE [NUM_DENOMS] = '{50, 20, 10, 5, 1};

endpackage

// File: rtl/vend_change_gen.sv
// Greedy coin selector: picks the largest denomination not exceeding the
// amount still owed. Shared by the change and refund paths.
module vend_change_gen
  import vend_pkg::*;
#(
  parameter int CURRENCY_WIDTH = 7
) (
  input  logic [CURRENCY_WIDTH-1:0] remaining,
  output logic [2:0]                coin_denom,
  output logic [CURRENCY_WIDTH-1:0] coin_value
);

  // Scan smallest to largest so the last hit is the largest coin that fits.
  always_comb begin
    coin_denom = '0;
    coin_value = '0;
    for (int i = NUM_DENOMS - 1; i >= 0; i--) begin
      if (DENOM_VALUE[i] <= 32'(remaining)) begin
        coin_denom = 3'(i);
        coin_value = CURRENCY_WIDTH'(DENOM_VALUE[i]);
      end
    end
  end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Multi-cycle dispense controller: request handshake, stock/funds check,
// timed motor command, coin-by-coin change or refund, final status report.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int CURRENCY_WIDTH  = 7,
  parameter int ITEM_ADDR_WIDTH = 10,
  parameter int PRICE_WIDTH     = 16,
  parameter int COUNT_WIDTH     = 8,
  parameter int VEND_TIMEOUT    = 255
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ITEM_ADDR_WIDTH-1:0] item_selected,
  input  logic [CURRENCY_WIDTH-1:0]  total_currency,
  input  logic [PRICE_WIDTH-1:0]     item_price,
  input  logic [COUNT_WIDTH-1:0]     avail_count,
  output logic                       vend_req,
  output logic [ITEM_ADDR_WIDTH-1:0] vend_item,
  input  logic                       vend_done,
  output logic                       stock_dec,
  output logic                       coin_valid,
  output logic [2:0]                 coin_denom,
  input  logic                       coin_ready,
  output logic                       dispense_valid,
  output logic                       done_valid,
  output logic [1:0]                 done_status,
  output logic [ITEM_ADDR_WIDTH-1:0] item_dispensed,
  output logic [CURRENCY_WIDTH-1:0]  currency_change
);

  localparam int TIMER_W = $clog2(VEND_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(VEND_TIMEOUT - 1);

  state_t                      state, state_next;
  status_t                     status_r, status_next;
  logic [ITEM_ADDR_WIDTH-1:0]  item_r;
  logic [CURRENCY_WIDTH-1:0]   total_r;
  logic [PRICE_WIDTH-1:0]      price_r;
  logic [COUNT_WIDTH-1:0]      count_r;
  logic [CURRENCY_WIDTH-1:0]   remaining, remaining_next;
  logic [CURRENCY_WIDTH-1:0]   change_acc, change_next;
  logic [TIMER_W-1:0]          timer, timer_next;
  logic [2:0]                  denom_sel;
  logic [CURRENCY_WIDTH-1:0]   coin_value;
  logic                        accept;

  vend_change_gen #(
    .CURRENCY_WIDTH(CURRENCY_WIDTH)
  ) u_change_gen (
    .remaining (remaining),
    .coin_denom(denom_sel),
    .coin_value(coin_value)
  );

  // req_ready is gated by rstn so it reads low while reset is held.
  assign req_ready      = rstn && (state == IDLE);
  assign accept         = req_valid && req_ready;
  assign vend_req       = (state == VEND);
  assign vend_item      = (state == VEND) ? item_r : '0;
  assign stock_dec      = (state == VEND) && vend_done;
  assign coin_valid     = (state == CHANGE);
  assign coin_denom     = (state == CHANGE) ? denom_sel : 3'd0;
  assign done_valid     = (state == DONE);
  assign dispense_valid = (state == DONE) && (status_r == ST_OK);

  // Next-state and datapath updates; a zero amount owed skips CHANGE entirely.
  always_comb begin
    state_next     = state;
    status_next    = status_r;
    remaining_next = remaining;
    change_next    = change_acc;
    timer_next     = timer;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next  = CHECK;
          change_next = '0;
        end
      end
      CHECK: begin
        timer_next = '0;
        if (count_r == '0) begin
          status_next    = ST_NO_STOCK;
          remaining_next = total_r;
          state_next     = (total_r == '0) ? DONE : CHANGE;
        end else if (price_r > PRICE_WIDTH'(total_r)) begin
          status_next    = ST_NO_FUNDS;
          remaining_next = total_r;
          state_next     = (total_r == '0) ? DONE : CHANGE;
        end else begin
          state_next = VEND;
        end
      end
      VEND: begin
        timer_next = timer + 1'b1;
        if (vend_done) begin
          status_next    = ST_OK;
          remaining_next = total_r - price_r[CURRENCY_WIDTH-1:0];
          state_next     = (remaining_next == '0) ? DONE : CHANGE;
        end else if (timer == TIMEOUT_LAST) begin
          status_next    = ST_TIMEOUT;
          remaining_next = total_r;
          state_next     = (total_r == '0) ? DONE : CHANGE;
        end
      end
      CHANGE: begin
        if (coin_ready) begin
          remaining_next = remaining - coin_value;
          change_next    = change_acc + coin_value;
          if (remaining_next == '0) state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, request latches and the result registers held until the next DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      status_r        <= ST_OK;
      item_r          <= '0;
      total_r         <= '0;
      price_r         <= '0;
      count_r         <= '0;
      remaining       <= '0;
      change_acc      <= '0;
      timer           <= '0;
      done_status     <= '0;
      item_dispensed  <= '0;
      currency_change <= '0;
    end else begin
      state      <= state_next;
      status_r   <= status_next;
      remaining  <= remaining_next;
      change_acc <= change_next;
      timer      <= timer_next;
      if (accept) begin
        item_r  <= item_selected;
        total_r <= total_currency;
        price_r <= item_price;
        count_r <= avail_count;
      end
      if (state_next == DONE) begin
        done_status     <= status_next;
        item_dispensed  <= item_r;
        currency_change <= change_next;
      end
    end
  end

endmodule
